zap_tlb_walker: RTL

- Hardware page-table walker that sequences refill of the four TLBs (section, large, small, fine) after the TLB checker raises its walk request.
- Fetches the L1 descriptor and, if needed, the L2 descriptor over a Wishbone-classic master port.
- On success, writes exactly one TLB entry. On failure, returns a translation or external-abort FSR/FAR.
- Sits between the TLB checker/TLB RAMs and the cache-side memory arbiter; one instance per I/D side.

---
 rtl/zap_tlb_walker_pkg.sv | 65 ++++++
 rtl/zap_tlb_walk_decode.sv | 43 ++++
 rtl/zap_tlb_walker.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/zap_tlb_walker_pkg.sv
// zap_tlb_walker_pkg: descriptor codes, fault status codes, TLB entry layouts and
// walker state types shared by the page-table walker and its descriptor decoder.
package zap_tlb_walker_pkg;

   localparam logic [1:0] DESC_FAULT   = 2'b00;
   localparam logic [1:0] DESC_COARSE  = 2'b01;
   localparam logic [1:0] DESC_SECTION = 2'b10;
   localparam logic [1:0] DESC_FINE    = 2'b11;

   localparam logic [1:0] PTE_FAULT = 2'b00;
   localparam logic [1:0] PTE_LARGE = 2'b01;
   localparam logic [1:0] PTE_SMALL = 2'b10;
   localparam logic [1:0] PTE_FINE  = 2'b11;

   localparam logic [3:0] FS_SECTION_XLATE = 4'h5;
   localparam logic [3:0] FS_PAGE_XLATE    = 4'h7;
   localparam logic [3:0] FS_L1_EXT_ABORT  = 4'hC;
   localparam logic [3:0] FS_L2_EXT_ABORT  = 4'hE;

   localparam int ZAP_SECTION_TLB_WDT = 32;
   localparam int ZAP_LPAGE_TLB_WDT   = 46;
   localparam int ZAP_SPAGE_TLB_WDT   = 54;
   localparam int ZAP_FPAGE_TLB_WDT   = 52;

   typedef struct packed {
      logic [11:0] va_tag;
      logic [11:0] pa_base;
      logic [1:0]  ap;
      logic [3:0]  dom;
      logic [1:0]  cb;
   } section_entry_t;

   typedef struct packed {
      logic [15:0] va_tag;
      logic [15:0] pa_base;
      logic [7:0]  ap;
      logic [3:0]  dom;
      logic [1:0]  cb;
   } lpage_entry_t;

   typedef struct packed {
      logic [19:0] va_tag;
      logic [19:0] pa_base;
      logic [7:0]  ap;
      logic [3:0]  dom;
      logic [1:0]  cb;
   } spage_entry_t;

   typedef struct packed {
      logic [21:0] va_tag;
      logic [21:0] pa_base;
      logic [1:0]  ap;
      logic [3:0]  dom;
      logic [1:0]  cb;
   } fpage_entry_t;

   typedef enum logic [2:0] {
      S_IDLE, S_L1_REQ, S_L1_DEC, S_L2_REQ, S_L2_DEC, S_WRITE, S_FAULT, S_DONE_WAIT
   } walk_state_t;

   typedef enum logic [2:0] {
      C_NEXT, C_SECTION, C_LARGE, C_SMALL, C_FINE, C_FAULT
   } walk_cls_t;

endpackage

// File: rtl/zap_tlb_walk_decode.sv
// zap_tlb_walk_decode: classifies the latched L1/L2 descriptors and builds the
// L2 fetch address, the four candidate TLB entries and the translation-fault FSR.
module zap_tlb_walk_decode
   import zap_tlb_walker_pkg::*;
(
   input  logic           lvl2_i,
   input  logic [31:0]    va_i,
   input  logic [31:0]    l1_i,
   input  logic [31:0]    l2_i,
   output walk_cls_t      cls_o,
   output logic [31:0]    l2_adr_o,
   output logic [7:0]     fsr_o,
   output section_entry_t se_o,
   output lpage_entry_t   le_o,
   output spage_entry_t   pe_o,
   output fpage_entry_t   fe_o
);

   logic [3:0] dom;
   logic       fine_l1;
   logic       unused_bits;

   assign dom     = l1_i[8:5];
   assign fine_l1 = l1_i[1:0] == DESC_FINE;
   assign unused_bits = ^{va_i[9:0], l1_i[9], l1_i[4]};

   // A fine-page (11) L2 descriptor is only legal beneath a fine L1 table.
   assign cls_o = !lvl2_i ? (l1_i[1:0] == DESC_SECTION ? C_SECTION :
                             l1_i[1:0] == DESC_FAULT   ? C_FAULT   : C_NEXT) :
                  l2_i[1:0] == PTE_LARGE ? C_LARGE :
                  l2_i[1:0] == PTE_SMALL ? C_SMALL :
                  (l2_i[1:0] == PTE_FINE && fine_l1) ? C_FINE : C_FAULT;

   assign fsr_o    = lvl2_i ? {dom, FS_PAGE_XLATE} : {4'h0, FS_SECTION_XLATE};
   assign l2_adr_o = fine_l1 ? {l1_i[31:12], va_i[19:10], 2'b00}
                             : {l1_i[31:10], va_i[19:12], 2'b00};

   assign se_o = {va_i[31:20], l1_i[31:20], l1_i[11:10], dom, l1_i[3:2]};
   assign le_o = {va_i[31:16], l2_i[31:16], l2_i[11:4], dom, l2_i[3:2]};
   assign pe_o = {va_i[31:12], l2_i[31:12], l2_i[11:4], dom, l2_i[3:2]};
   assign fe_o = {va_i[31:10], l2_i[31:10], l2_i[5:4], dom, l2_i[3:2]};

endmodule

// File: rtl/zap_tlb_walker.sv
// zap_tlb_walker: page-table walker that fetches L1/L2 descriptors over a
// Wishbone-classic master and refills one TLB entry or reports a fault.
module zap_tlb_walker
   import zap_tlb_walker_pkg::*;
#(
   parameter int LPAGE_TLB_ENTRIES   = 8,
   parameter int SPAGE_TLB_ENTRIES   = 8,
   parameter int SECTION_TLB_ENTRIES = 8,
   parameter int FPAGE_TLB_ENTRIES   = 8
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_mmu_en,
   input  logic                           i_walk,
   input  logic [31:0]                    i_va,
   input  logic [17:0]                    i_baddr,
   output logic                           o_wb_cyc,
   output logic                           o_wb_stb,
   output logic [31:0]                    o_wb_adr,
   input  logic [31:0]                    i_wb_dat,
   input  logic                           i_wb_ack,
   input  logic                           i_wb_err,
   output logic                           o_setlb_wen,
   output logic                           o_lptlb_wen,
   output logic                           o_sptlb_wen,
   output logic                           o_fptlb_wen,
   output logic [ZAP_SECTION_TLB_WDT-1:0] o_setlb_wdata,
   output logic [ZAP_LPAGE_TLB_WDT-1:0]   o_lptlb_wdata,
   output logic [ZAP_SPAGE_TLB_WDT-1:0]   o_sptlb_wdata,
   output logic [ZAP_FPAGE_TLB_WDT-1:0]   o_fptlb_wdata,
   output logic [2:0]                     o_tlb_widx,
   output logic                           o_fault,
   output logic [7:0]                     o_fsr,
   output logic [31:0]                    o_far,
   output logic                           o_done,
   output logic                           o_busy
);

   walk_state_t    state_q;
   logic [31:0]    va_q, l1_q, l2_q;
   walk_cls_t      cls;
   logic [31:0]    l2_adr;
   logic [7:0]     dec_fsr;
   section_entry_t se;
   lpage_entry_t   le;
   spage_entry_t   pe;
   fpage_entry_t   fe;
   logic [2:0]     sec_idx, lp_idx, sp_idx, fp_idx;

   zap_tlb_walk_decode u_decode (
      .lvl2_i   (state_q == S_L2_DEC),
      .va_i     (va_q),
      .l1_i     (l1_q),
      .l2_i     (l2_q),
      .cls_o    (cls),
      .l2_adr_o (l2_adr),
      .fsr_o    (dec_fsr),
      .se_o     (se),
      .le_o     (le),
      .pe_o     (pe),
      .fe_o     (fe)
   );

   assign sec_idx = 3'(va_q[31:20] & 12'(SECTION_TLB_ENTRIES - 1));
   assign lp_idx  = 3'(va_q[31:16] & 16'(LPAGE_TLB_ENTRIES - 1));
   assign sp_idx  = 3'(va_q[31:12] & 20'(SPAGE_TLB_ENTRIES - 1));
   assign fp_idx  = 3'(va_q[31:10] & 22'(FPAGE_TLB_ENTRIES - 1));
   assign o_busy  = state_q != S_IDLE;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= S_IDLE;
         va_q          <= '0;
         l1_q          <= '0;
         l2_q          <= '0;
         o_wb_cyc      <= 1'b0;
         o_wb_stb      <= 1'b0;
         o_wb_adr      <= '0;
         o_setlb_wen   <= 1'b0;
         o_lptlb_wen   <= 1'b0;
         o_sptlb_wen   <= 1'b0;
         o_fptlb_wen   <= 1'b0;
         o_setlb_wdata <= '0;
         o_lptlb_wdata <= '0;
         o_sptlb_wdata <= '0;
         o_fptlb_wdata <= '0;
         o_tlb_widx    <= '0;
         o_fault       <= 1'b0;
         o_fsr         <= '0;
         o_far         <= '0;
         o_done        <= 1'b0;
      end else begin
         o_setlb_wen <= 1'b0;
         o_lptlb_wen <= 1'b0;
         o_sptlb_wen <= 1'b0;
         o_fptlb_wen <= 1'b0;
         o_fault     <= 1'b0;
         o_done      <= 1'b0;
         o_fsr       <= '0;
         o_far       <= '0;
         case (state_q)
            S_IDLE: if (i_mmu_en && i_walk) begin
               va_q     <= i_va;
               o_wb_adr <= {i_baddr, i_va[31:20], 2'b00};
               o_wb_cyc <= 1'b1;
               o_wb_stb <= 1'b1;
               state_q  <= S_L1_REQ;
            end
            S_L1_REQ, S_L2_REQ: if (i_wb_ack || i_wb_err) begin
               o_wb_cyc <= 1'b0;
               o_wb_stb <= 1'b0;
               if (state_q == S_L1_REQ) l1_q <= i_wb_dat;
               else l2_q <= i_wb_dat;
               // A walk abandoned by MMU disable still lets the bus cycle finish.
               if (!i_mmu_en) state_q <= S_DONE_WAIT;
               else if (i_wb_err) begin
                  o_fault <= 1'b1;
                  o_done  <= 1'b1;
                  o_far   <= va_q;
                  o_fsr   <= state_q == S_L1_REQ ? {4'h0, FS_L1_EXT_ABORT} : {l1_q[8:5], FS_L2_EXT_ABORT};
                  state_q <= S_FAULT;
               end else state_q <= state_q == S_L1_REQ ? S_L1_DEC : S_L2_DEC;
            end
            S_L1_DEC, S_L2_DEC:
               if (!i_mmu_en) state_q <= S_DONE_WAIT;
               else if (cls == C_NEXT) begin
                  o_wb_adr <= l2_adr;
                  o_wb_cyc <= 1'b1;
                  o_wb_stb <= 1'b1;
                  state_q  <= S_L2_REQ;
               end else if (cls == C_FAULT) begin
                  o_fault <= 1'b1;
                  o_done  <= 1'b1;
                  o_far   <= va_q;
                  o_fsr   <= dec_fsr;
                  state_q <= S_FAULT;
               end else begin
                  o_setlb_wen   <= cls == C_SECTION;
                  o_lptlb_wen   <= cls == C_LARGE;
                  o_sptlb_wen   <= cls == C_SMALL;
                  o_fptlb_wen   <= cls == C_FINE;
                  o_setlb_wdata <= se;
                  o_lptlb_wdata <= le;
                  o_sptlb_wdata <= pe;
                  o_fptlb_wdata <= fe;
                  o_tlb_widx    <= cls == C_SECTION ? sec_idx : cls == C_LARGE ? lp_idx :
                                   cls == C_SMALL ? sp_idx : fp_idx;
                  o_done        <= 1'b1;
                  state_q       <= S_WRITE;
               end
            S_WRITE, S_FAULT: state_q <= S_DONE_WAIT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
